// File: rtl/neuron_seq_ctrl.sv
// Sequencer that buffers {W,X} operand pairs and streams them to a downstream
// MAC/ReLU neuron, then captures and presents the neuron's result.
module neuron_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_w,
  input  logic [WIDTH-1:0] ld_x,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             mac_clr,
  output logic             en,
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] neuron_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StCapture,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] res_data_q;
  logic [WIDTH-1:0] mem_w [DEPTH];
  logic [WIDTH-1:0] mem_x [DEPTH];
  logic             load;

  assign ld_ready = (state_q == StIdle) && (count_q < DepthC);
  assign load     = ld_valid && ld_ready;

  // Next-state, pointer and count logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (load) begin
      count_d = count_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        // count_d already includes a same-cycle load, so the run sees it.
        if (start && (count_d != '0)) begin
          state_d = StClear;
        end
      end
      StClear: state_d = StRun;
      StRun: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (rd_ptr_d == count_q) begin
          state_d = StDrain;
        end
      end
      StDrain:   state_d = StCapture;
      StCapture: state_d = StDone;
      StDone: begin
        if (res_ready) begin
          state_d  = StIdle;
          count_d  = '0;
          rd_ptr_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Result register, only written while capturing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data_q <= '0;
    end else if (state_q == StCapture) begin
      res_data_q <= neuron_out;
    end
  end

  // Operand buffer; entries at or above count are never read, so no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      mem_w[count_q[AW-1:0]] <= ld_w;
      mem_x[count_q[AW-1:0]] <= ld_x;
    end
  end

  // Output decode from state.
  always_comb begin
    busy      = (state_q != StIdle);
    mac_clr   = (state_q == StClear);
    en        = (state_q == StRun);
    res_valid = (state_q == StDone);
    W         = '0;
    X         = '0;
    if (state_q == StRun) begin
      W = mem_w[rd_ptr_q[AW-1:0]];
      X = mem_x[rd_ptr_q[AW-1:0]];
    end
  end

  assign count    = count_q;
  assign res_data = res_data_q;

endmodule
